step_ctrl_unit: RTL and testbench

- Parametrised step controller for the parallel bilinear downscaling datapath. It is the successor of the single-register step decoder.
- Decodes the host control register into free-run, single-step or N-step burst operation, with a handshake to the pipeline (`pipe_ready` / `pipe_done`).
- Produces registered step strobes, masked per lane, for NUM_LANES parallel interpolation lanes.
- Sits between the host register file and the downscaler lane array.

---
 rtl/step_pkg.sv | 17 +
 rtl/step_edge_det.sv | 24 ++
 rtl/step_ctrl_unit.sv | 200 ++++++++++++++++++++
 tb/tb_step_ctrl_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the step controller.
//   step_state_t : controller FSM states
//   CTRL_*       : bit positions inside the host control register
package step_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RDY  = 2'd1,
    S_WAIT_DONE = 2'd2
  } step_state_t;

  localparam int unsigned CTRL_STEP_REQ  = 0;
  localparam int unsigned CTRL_STEP_MODE = 1;
  localparam int unsigned CTRL_BURST_EN  = 2;
  localparam int unsigned CTRL_HALT      = 3;

endpackage

// File: rtl/step_edge_det.sv
// Registered rising-edge detector.
//   clk, aclr : clock and asynchronous active-low reset
//   sig_in    : level to watch
//   rise      : high in the cycle where sig_in is high but was low at the previous edge
module step_edge_det (
  input  logic clk,
  input  logic aclr,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/step_ctrl_unit.sv
// Step controller for the parallel bilinear downscaler lane array.
// Decodes the host control register into free-run, single-step or N-step burst
// operation and issues registered, per-lane masked step strobes.
// Ports:
//   clk, aclr              : clock, asynchronous active-low reset
//   ctrl_reg               : bit0 step_req, bit1 step_mode, bit2 burst_en, bit3 halt
//   burst_len              : steps per burst (0 behaves as 1)
//   lane_mask              : lanes enabled for the next accepted request
//   pipe_ready, pipe_done  : pipeline handshake
//   step_mode, step_pulse, lane_step, busy, step_ack, req_dropped, steps_done : registered status
// Optional build macro STEP_TIMEOUT_EN adds a watchdog on S_WAIT_DONE and the
// sticky timeout_err output.
module step_ctrl_unit
  import step_pkg::*;
#(
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic [CTRL_W-1:0]    ctrl_reg,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 pipe_ready,
  input  logic                 pipe_done,
  output logic                 step_mode,
  output logic                 step_pulse,
  output logic [NUM_LANES-1:0] lane_step,
  output logic                 busy,
  output logic                 step_ack,
  output logic                 req_dropped,
  output logic [CNT_W-1:0]     steps_done
`ifdef STEP_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  step_state_t          state_q, state_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic                 dropped_q, dropped_d;
  logic                 step_pulse_q, step_pulse_d;
  logic [NUM_LANES-1:0] lane_step_q, lane_step_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 mode_q;
  logic [CNT_W-1:0]     steps_done_q, steps_done_d;
  logic                 req_rise;

  logic mode_in, halt, burst_en, unused_ctrl;
  assign mode_in     = ctrl_reg[CTRL_STEP_MODE];
  assign halt        = ctrl_reg[CTRL_HALT];
  assign burst_en    = ctrl_reg[CTRL_BURST_EN];
  assign unused_ctrl = ^ctrl_reg;

`ifdef STEP_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           tout_q, tout_d;
`endif

  step_edge_det u_req_edge (
    .clk    (clk),
    .aclr   (aclr),
    .sig_in (ctrl_reg[CTRL_STEP_REQ]),
    .rise   (req_rise)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    mask_d       = mask_q;
    dropped_d    = dropped_q;
    step_pulse_d = 1'b0;
    ack_d        = 1'b0;
`ifdef STEP_TIMEOUT_EN
    tout_d       = tout_q;
`endif
    if (!mode_in) begin
      // Free run: FSM parked, every ready cycle not halted yields a step on all lanes.
      state_d      = S_IDLE;
      remaining_d  = '0;
      mask_d       = '1;
      step_pulse_d = pipe_ready & ~halt;
    end else if (halt) begin
      // Halt beats everything, including a simultaneous request.
      state_d     = S_IDLE;
      remaining_d = '0;
      if (req_rise) dropped_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_rise) begin
            if (lane_mask != '0) begin
              mask_d      = lane_mask;
              remaining_d = (burst_en && burst_len != '0) ? burst_len : CNT_W'(1);
              dropped_d   = 1'b0;
              state_d     = S_WAIT_RDY;
`ifdef STEP_TIMEOUT_EN
              tout_d      = 1'b0;
`endif
            end else begin
              dropped_d = 1'b1;
            end
          end
        end
        S_WAIT_RDY: begin
          if (req_rise) dropped_d = 1'b1;
          if (pipe_ready) begin
            step_pulse_d = 1'b1;
            remaining_d  = remaining_q - CNT_W'(1);
            state_d      = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (req_rise) dropped_d = 1'b1;
          // pipe_done is ignored during the pulse cycle itself.
          if (pipe_done && !step_pulse_q) begin
            if (remaining_q == '0) begin
              ack_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_RDY;
            end
          end
`ifdef STEP_TIMEOUT_EN
          else if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            tout_d      = 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    lane_step_d  = step_pulse_d ? mask_d : '0;
    busy_d       = (state_d != S_IDLE);
    steps_done_d = steps_done_q + CNT_W'(step_pulse_d);
  end

`ifdef STEP_TIMEOUT_EN
  // Counts cycles spent in S_WAIT_DONE; zero on entry.
  always_comb begin
    wdog_d = '0;
    if (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) wdog_d = wdog_q + WdW'(1);
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wdog_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tout_q <= tout_d;
    end
  end

  assign timeout_err = tout_q;
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      mask_q       <= '0;
      dropped_q    <= 1'b0;
      step_pulse_q <= 1'b0;
      lane_step_q  <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      mode_q       <= 1'b0;
      steps_done_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      mask_q       <= mask_d;
      dropped_q    <= dropped_d;
      step_pulse_q <= step_pulse_d;
      lane_step_q  <= lane_step_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      mode_q       <= mode_in;
      steps_done_q <= steps_done_d;
    end
  end

  assign step_mode   = mode_q;
  assign step_pulse  = step_pulse_q;
  assign lane_step   = lane_step_q;
  assign busy        = busy_q;
  assign step_ack    = ack_q;
  assign req_dropped = dropped_q;
  assign steps_done  = steps_done_q;

endmodule

// File: tb/tb_step_ctrl_unit.sv
// Randomised self-checking bench for step_ctrl_unit with a behavioural model.
module tb_step_ctrl_unit;

  localparam int unsigned TOUT = 8;

  logic        clk = 1'b0;
  logic        aclr;
  logic [7:0]  ctrl_reg;
  logic [15:0] burst_len;
  logic [3:0]  lane_mask;
  logic        pipe_ready, pipe_done;
  logic        step_mode, step_pulse, busy, step_ack, req_dropped;
  logic [3:0]  lane_step;
  logic [15:0] steps_done;
`ifdef STEP_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  step_ctrl_unit #(
    .CTRL_W      (8),
    .CNT_W       (16),
    .NUM_LANES   (4),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .ctrl_reg    (ctrl_reg),
    .burst_len   (burst_len),
    .lane_mask   (lane_mask),
    .pipe_ready  (pipe_ready),
    .pipe_done   (pipe_done),
    .step_mode   (step_mode),
    .step_pulse  (step_pulse),
    .lane_step   (lane_step),
    .busy        (busy),
    .step_ack    (step_ack),
    .req_dropped (req_dropped),
    .steps_done  (steps_done)
`ifdef STEP_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A request is "active" from acceptance until ack/abort; within it the model
  // either wants a pulse (not waiting) or waits for the pipeline's done.
  logic        m_req_prev, m_active, m_waiting, m_fresh, m_drop, m_tout;
  int unsigned m_left, m_wcnt;
  logic [3:0]  m_mask;
  logic        e_pulse, e_ack, e_mode;
  logic [3:0]  e_lane;
  logic [15:0] e_steps;

  always @(posedge clk or negedge aclr) begin : mdl
    logic rise, halt, mode, fresh;
    if (!aclr) begin
      m_req_prev = 0; m_active = 0; m_waiting = 0; m_fresh = 0; m_drop = 0; m_tout = 0;
      m_left = 0; m_wcnt = 0; m_mask = 0;
      e_pulse = 0; e_ack = 0; e_mode = 0; e_lane = 0; e_steps = 0;
    end else begin
      rise = ctrl_reg[0] & ~m_req_prev;
      m_req_prev = ctrl_reg[0];
      mode  = ctrl_reg[1];
      halt  = ctrl_reg[3];
      fresh = m_fresh;
      e_pulse = 0;
      e_ack   = 0;
      if (!mode) begin
        e_pulse = pipe_ready & ~halt;
        m_mask = 4'hF; m_active = 0; m_waiting = 0;
      end else if (halt) begin
        if (rise) m_drop = 1;
        m_active = 0; m_waiting = 0;
      end else if (!m_active) begin
        if (rise) begin
          if (lane_mask != 0) begin
            m_mask = lane_mask;
            m_left = (ctrl_reg[2] && burst_len != 0) ? burst_len : 1;
            m_drop = 0; m_tout = 0; m_active = 1; m_waiting = 0;
          end else begin
            m_drop = 1;
          end
        end
      end else begin
        if (rise) m_drop = 1;
        if (!m_waiting) begin
          if (pipe_ready) begin
            e_pulse = 1; m_left--; m_waiting = 1; m_wcnt = 0;
          end
        end else if (pipe_done && !fresh) begin
          m_waiting = 0;
          if (m_left == 0) begin
            e_ack = 1; m_active = 0;
          end
        end else begin
          m_wcnt++;
`ifdef STEP_TIMEOUT_EN
          if (m_wcnt == TOUT) begin
            m_active = 0; m_waiting = 0; m_tout = 1;
          end
`endif
        end
      end
      m_fresh = e_pulse;
      e_mode  = mode;
      e_lane  = e_pulse ? m_mask : 4'h0;
      e_steps = e_steps + 16'(e_pulse);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("step_mode",   step_mode,   e_mode);
    chk("step_pulse",  step_pulse,  e_pulse);
    chk("lane_step",   lane_step,   e_lane);
    chk("busy",        busy,        m_active);
    chk("step_ack",    step_ack,    e_ack);
    chk("req_dropped", req_dropped, m_drop);
    chk("steps_done",  steps_done,  e_steps);
`ifdef STEP_TIMEOUT_EN
    chk("timeout_err", timeout_err, m_tout);
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int pulses, acks;
  logic [15:0] base;

  initial begin
    aclr = 0; ctrl_reg = 0; burst_len = 0; lane_mask = 0; pipe_ready = 0; pipe_done = 0;
    repeat (3) tick();
    aclr = 1;
    chk("rst_steps_done", steps_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", step_pulse, 0);

    // Single step, mask 0101.
    ctrl_reg = 8'h02; lane_mask = 4'b0101; pipe_ready = 1; tick();
    ctrl_reg = 8'h03; tick();
    chk("ss_pulse_early", step_pulse, 0);
    chk("ss_busy", busy, 1);
    tick();
    chk("ss_pulse", step_pulse, 1);
    chk("ss_model_pulse", e_pulse, 1);
    chk("ss_lane", lane_step, 4'b0101);
    chk("ss_count", steps_done, 1);
    pipe_ready = 0; tick();
    chk("ss_one_cycle", step_pulse, 0);
    tick(); tick();
    pipe_done = 1;
    chk("ss_no_early_ack", step_ack, 0);
    tick();
    pipe_done = 0;
    chk("ss_ack", step_ack, 1);
    chk("ss_model_ack", e_ack, 1);
    chk("ss_idle", busy, 0);
    tick();
    chk("ss_ack_once", step_ack, 0);

    // Request with empty mask.
    ctrl_reg = 8'h02; lane_mask = 4'b0000; tick();
    ctrl_reg = 8'h03; tick();
    chk("mask0_dropped", req_dropped, 1);
    chk("mask0_busy", busy, 0);

    // Burst of 3 with a second request edge while busy.
    ctrl_reg = 8'h06; lane_mask = 4'hF; burst_len = 3; pipe_ready = 1; pipe_done = 1; tick();
    base = steps_done;
    ctrl_reg = 8'h07; pulses = 0; acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(step_pulse); acks += int'(step_ack);
      if (i == 2) ctrl_reg = 8'h06;
      if (i == 3) ctrl_reg = 8'h07;
    end
    chk("burst3_pulses", pulses, 3);
    chk("burst3_acks", acks, 1);
    chk("burst3_steps", steps_done - base, 3);
    chk("busy_dropped", req_dropped, 1);

    // Burst length 0 behaves as 1.
    burst_len = 0; ctrl_reg = 8'h06; tick();
    ctrl_reg = 8'h07; pulses = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(step_pulse); acks += int'(step_ack);
    end
    chk("burst0_pulses", pulses, 1);
    chk("burst0_acks", acks, 1);
    chk("burst0_drop_clr", req_dropped, 0);

    // Free run, then halt.
    ctrl_reg = 8'h00; pipe_ready = 1; pipe_done = 0; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(step_pulse);
      chk("free_lane", lane_step, 4'hF);
    end
    chk("free_pulses", pulses, 5);
    ctrl_reg = 8'h08; tick();
    chk("free_halt", step_pulse, 0);

    // Halt in S_WAIT_DONE aborts without ack.
    ctrl_reg = 8'h02; tick();
    ctrl_reg = 8'h03; tick(); tick();
    chk("abort_pulse", step_pulse, 1);
    ctrl_reg = 8'h0B; tick();
    chk("abort_busy", busy, 0);
    chk("abort_ack", step_ack, 0);
    ctrl_reg = 8'h02; tick();

`ifdef STEP_TIMEOUT_EN
    ctrl_reg = 8'h03; pipe_ready = 1; pipe_done = 0; tick(); tick();
    repeat (7) tick();
    chk("tout_not_yet", timeout_err, 0);
    tick();
    chk("tout_err", timeout_err, 1);
    chk("tout_idle", busy, 0);
    ctrl_reg = 8'h02; tick();
`endif

    // Reset mid-burst.
    burst_len = 4; ctrl_reg = 8'h06; lane_mask = 4'hA; pipe_ready = 1; pipe_done = 0; tick();
    ctrl_reg = 8'h07; tick(); tick();
    #2 aclr = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulse", step_pulse, 0);
    chk("mid_rst_steps", steps_done, 0);
    chk("mid_rst_lane", lane_step, 0);
    tick();
    aclr = 1; ctrl_reg = 8'h00;

    // Randomised traffic, compared every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) ctrl_reg[0] = ~ctrl_reg[0];
      ctrl_reg[1]   = ($urandom_range(0, 99) < 92);
      ctrl_reg[2]   = 1'($urandom_range(0, 1));
      ctrl_reg[3]   = ($urandom_range(0, 99) < 3);
      ctrl_reg[7:4] = 4'($urandom);
      if ($urandom_range(0, 7) == 0) burst_len = 16'($urandom_range(0, 4));
      lane_mask  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
      pipe_ready = ($urandom_range(0, 9) < 7);
      pipe_done  = ($urandom_range(0, 9) < 4);
      if (c == 1500) begin
        #2 aclr = 0;
        tick();
        aclr = 1;
      end
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
